// File: rtl/sprite_pkg.sv
// Shared constants, state/direction enums and small decode helpers for the
// sprite animation sequencer.
package sprite_pkg;
  localparam logic [7:0] KEY_RIGHT      = 8'd79;
  localparam logic [7:0] KEY_LEFT       = 8'd80;
  localparam logic [3:0] SEL_RIGHT_IDLE = 4'd8;
  localparam logic [3:0] SEL_LEFT_IDLE  = 4'd4;

  typedef enum logic [1:0] {IDLE, WALK, TURN} anim_state_e;
  typedef enum logic [1:0] {NONE, RIGHT, LEFT} dir_req_e;

  function automatic dir_req_e decode_key(input logic [7:0] kc);
    if (kc == KEY_RIGHT) return RIGHT;
    else if (kc == KEY_LEFT) return LEFT;
    else return NONE;
  endfunction

  // Idle/turn poses sit at the facing base; walk poses follow it.
  function automatic logic [3:0] sel_of(input anim_state_e st, input logic fc,
                                        input logic [1:0] pose);
    logic [3:0] base;
    base = fc ? SEL_LEFT_IDLE : SEL_RIGHT_IDLE;
    return (st == WALK) ? base + 4'd1 + {2'b00, pose} : base;
  endfunction
endpackage

// File: rtl/anim_tick_counter.sv
// Frame counter 0..N-1; wrap flags the last count so the owner can act on
// the edge that rolls it back to zero.
module anim_tick_counter #(
  parameter int N = 8
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  assign wrap = (cnt == W'(N - 1));

  always_ff @(posedge frame_clk) begin
    if (Reset || clr) cnt <= '0;
    else if (en)      cnt <= wrap ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/sprite_anim_sequencer.sv
// Walk/turn/idle sprite sequencer: picks the sprite index each frame from the
// arrow keys, holding walk poses and the turn pose for a fixed frame count.
module sprite_anim_sequencer #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int TURN_FRAMES     = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] Keycode,
  input  logic       pause,
  output logic [3:0] sel,
  output logic       moving,
  output logic       facing,
  output logic       step_pulse
);
  import sprite_pkg::*;

  anim_state_e state, state_nxt;
  logic [1:0]  pose, pose_nxt;
  logic        facing_nxt, pulse_nxt;
  dir_req_e    dir;
  logic        key_match, key_opp;
  logic        fc_en, fc_clr, fc_wrap;
  logic        tc_en, tc_clr, tc_last;

  assign dir       = decode_key(Keycode);
  assign key_match = (dir == RIGHT && !facing) || (dir == LEFT && facing);
  assign key_opp   = (dir != NONE) && !key_match;

  // Counters run only while their state persists; any other unpaused edge
  // clears them, so entering WALK or TURN always starts from zero.
  assign fc_en  = !pause && (state == WALK) && key_match;
  assign fc_clr = !pause && !fc_en;
  assign tc_en  = !pause && (state == TURN) && !tc_last;
  assign tc_clr = !pause && !tc_en;

  anim_tick_counter #(.N(FRAMES_PER_STEP)) u_frame_cnt (
    .frame_clk(frame_clk), .Reset(Reset), .en(fc_en), .clr(fc_clr), .wrap(fc_wrap)
  );

  anim_tick_counter #(.N(TURN_FRAMES)) u_turn_cnt (
    .frame_clk(frame_clk), .Reset(Reset), .en(tc_en), .clr(tc_clr), .wrap(tc_last)
  );

  always_comb begin
    state_nxt  = state;
    facing_nxt = facing;
    pose_nxt   = pose;
    pulse_nxt  = 1'b0;
    if (!pause) begin
      case (state)
        IDLE: begin
          if (key_match) begin
            state_nxt = WALK;
            pose_nxt  = 2'd0;
          end else if (key_opp) begin
            state_nxt  = TURN;
            facing_nxt = ~facing;
          end
        end
        WALK: begin
          if (dir == NONE) begin
            state_nxt = IDLE;
            pose_nxt  = 2'd0;
          end else if (key_opp) begin
            state_nxt  = TURN;
            facing_nxt = ~facing;
            pose_nxt   = 2'd0;
          end else if (fc_wrap) begin
            pose_nxt  = (pose == 2'd2) ? 2'd0 : pose + 2'd1;
            pulse_nxt = (pose == 2'd2);
          end
        end
        TURN: begin
          // Keys are only looked at on the last turn frame; an opposite key
          // there lands in IDLE rather than flipping again.
          if (tc_last) begin
            state_nxt = key_match ? WALK : IDLE;
            pose_nxt  = 2'd0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      facing     <= 1'b0;
      pose       <= 2'd0;
      sel        <= SEL_RIGHT_IDLE;
      moving     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      facing     <= facing_nxt;
      pose       <= pose_nxt;
      sel        <= sel_of(state_nxt, facing_nxt, pose_nxt);
      moving     <= (state_nxt == WALK);
      step_pulse <= pulse_nxt;
    end
  end
endmodule

// File: doc/sprite_anim_sequencer.md
SPRITE_ANIM_SEQUENCER -- requirements
Module: sprite_anim_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_STEP, default 8: frames each walk pose is held (legal range 2..64).
REQ-002 SHALL have parameter TURN_FRAMES, default 4: frames the turn pose is held on a direction reversal (legal range 1..64).
REQ-003 SHALL have port frame_clk, input, 1 bit: the only clock, one rising edge per vertical sync.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Keycode, input, 8 bits: current keyboard code; 79 = right, 80 = left, any other value = none.
REQ-006 SHALL have port pause, input, 1 bit: freezes all state while high.
REQ-007 SHALL have port sel, output, 4 bits: registered sprite-select index driven to the sprite datapath.
REQ-008 SHALL have port moving, output, 1 bit: registered; high only in state WALK.
REQ-009 SHALL have port facing, output, 1 bit: registered; 0 = right, 1 = left.
REQ-010 SHALL have port step_pulse, output, 1 bit: registered one-frame pulse marking completion of a full stride.

Function
REQ-011 SHALL implement an FSM with states IDLE, WALK and TURN; all state is updated on the frame_clk rising edge only.
REQ-012 SHALL decode Keycode into dir_req = {NONE, RIGHT, LEFT}; a key matches when its direction equals facing, and is opposite otherwise.
REQ-013 In IDLE: a matching key SHALL enter WALK with pose=0 and frame counter=0; an opposite key SHALL enter TURN, toggle facing and load the turn counter with 0; NONE SHALL stay in IDLE.
REQ-014 In WALK: each edge SHALL increment the frame counter.
REQ-015 In WALK: at counter = FRAMES_PER_STEP-1 the counter SHALL wrap to 0 and pose SHALL advance 0->1->2->0.
REQ-016 In WALK: the pose 2->0 wrap SHALL assert step_pulse for exactly that one frame.
REQ-017 In WALK: NONE SHALL go to IDLE and an opposite key SHALL go to TURN (toggle facing); both SHALL clear pose and counter.
REQ-018 In TURN: Keycode SHALL be ignored until the turn counter reaches TURN_FRAMES-1.
REQ-019 On the TURN_FRAMES-1 edge: a matching key SHALL go to WALK (pose 0, counter 0), and NONE or an opposite key SHALL go to IDLE; no re-flip is allowed inside TURN.
REQ-020 sel encoding: facing right gives IDLE/TURN = 8 and WALK = 9+pose; facing left gives IDLE/TURN = 4 and WALK = 5+pose.
REQ-021 Outputs SHALL reflect the state written on the same edge (zero added latency beyond the register).
REQ-022 When pause=1: state, pose, counters and all outputs SHALL hold; step_pulse SHALL be 0.
REQ-023 When pause falls, counting SHALL resume from the held value, with no frame lost or repeated.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter.
REQ-025 Counters SHALL never exceed parameter-1, and pose SHALL never exceed 2.

Reset
REQ-026 Reset=1 on an edge SHALL force IDLE, facing=0, pose=0, both counters=0, sel=8, moving=0 and step_pulse=0, regardless of state.
REQ-027 Reset SHALL take priority over pause and Keycode.
REQ-028 Reset asserted mid-TURN or mid-WALK SHALL abort that state with no residual pulse.

Structure
REQ-029 Package sprite_pkg SHALL hold KEY_RIGHT=79, KEY_LEFT=80, SEL_RIGHT_IDLE=8, SEL_LEFT_IDLE=4, the state enum, and the dir_req enum.
REQ-030 The frame counter SHALL be a sub-module anim_tick_counter (enable, clear, wrap output), reused for the turn counter.

Verification (FRAMES_PER_STEP=8, TURN_FRAMES=4 unless stated)
REQ-031 Reset for 2 edges, Keycode=0 -> sel=8, moving=0, facing=0, step_pulse=0.
REQ-032 Hold Keycode=79 from IDLE -> edge1 sel=9 moving=1; edge9 sel=10; edge17 sel=11; edge25 sel=9 with step_pulse=1 for that frame only.
REQ-033 Walking right at sel=11, Keycode=0 -> next edge sel=8, moving=0; a new 79 restarts at sel=9.
REQ-034 Walking right, Keycode=80 held -> next edge sel=4, facing=1, moving=0; 4 edges later sel=5, moving=1; with Keycode=0 at that edge -> sel=4, IDLE.
REQ-035 pause=1 for 10 edges at counter=5, pose=1 -> sel frozen at 10 and no step_pulse; after release, sel=11 on the 3rd edge.
REQ-036 Reset=1 during TURN (facing=1, sel=4) with Keycode=80 and pause=1 -> next edge sel=8, facing=0, moving=0.
